// File: rtl/obs_pkg.sv
// Shared observation-event codes, target sequence table and requester-mode encodings
// for the sequence-match scheduler.
package obs_pkg;

  typedef enum logic [3:0] {
    NONE    = 4'd0,
    CLA_CLL = 4'd1,
    TAD     = 4'd2,
    DCA     = 4'd3,
    HLT     = 4'd4,
    JMP     = 4'd5,
    ISZ     = 4'd6,
    JMS     = 4'd7,
    IOT     = 4'd8,
    OTHER   = 4'd9
  } obs_code_t;

  localparam int unsigned SEQ_LEN = 6;
  localparam int unsigned STEP_W  = 3;
  localparam int unsigned CODE_W  = 4;

  localparam obs_code_t SEQ [SEQ_LEN] = '{CLA_CLL, TAD, TAD, DCA, HLT, JMP};

  localparam int unsigned MODE_BOTH      = 0;
  localparam int unsigned MODE_IFD_ONLY  = 1;
  localparam int unsigned MODE_EXEC_ONLY = 2;
  localparam int unsigned MODE_DISABLED  = 3;

  typedef enum logic [STEP_W-1:0] {
    S0 = 3'd0,
    S1 = 3'd1,
    S2 = 3'd2,
    S3 = 3'd3,
    S4 = 3'd4,
    S5 = 3'd5
  } match_state_t;

  // Expected code at a given matched-prefix length; NONE past the end of the table.
  function automatic obs_code_t seq_code(input logic [STEP_W-1:0] step);
    obs_code_t code;
    code = NONE;
    if (step < STEP_W'(SEQ_LEN)) code = SEQ[step];
    return code;
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-requester round-robin arbiter: on a tie, the grant goes to the requester
// that was not granted last (bit 0 = IFD, bit 1 = EXEC).
module rr_arb2 (
  input  logic [1:0] valid,
  input  logic       last,
  output logic [1:0] grant
);

  always_comb begin
    grant = valid;
    if (valid == 2'b11) grant = last ? 2'b01 : 2'b10;
  end

endmodule

// File: rtl/seq_match_scheduler.sv
// Arbitrates IFD/EXEC observation events into a single stream and tracks progress
// through the CLA_CLL,TAD,TAD,DCA,HLT,JMP pattern with a saturating hit counter.
module seq_match_scheduler
  import obs_pkg::*;
#(
  parameter int unsigned MODE  = 0,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             ifd_valid,
  input  logic [3:0]       ifd_code,
  output logic             ifd_ready,
  input  logic             exec_valid,
  input  logic [3:0]       exec_code,
  output logic             exec_ready,
  input  logic             clear,
  output logic [2:0]       seq_step,
  output logic             seq_hit,
  output logic [CNT_W-1:0] hit_count,
  output logic             last_grant
);

  localparam logic EN_IFD  = (MODE == MODE_BOTH) || (MODE == MODE_IFD_ONLY);
  localparam logic EN_EXEC = (MODE == MODE_BOTH) || (MODE == MODE_EXEC_ONLY);
  localparam logic DRAIN   = (MODE == MODE_DISABLED);

  match_state_t      state_q, state_d;
  logic              seq_hit_q, seq_hit_d;
  logic [CNT_W-1:0]  hit_count_q, hit_count_d;
  logic              last_grant_q, last_grant_d;

  logic [1:0]        req;
  logic [1:0]        grant;
  logic              accept;
  logic [CODE_W-1:0] in_code;
  logic              seq_done;

  assign req = {exec_valid & EN_EXEC, ifd_valid & EN_IFD};

  rr_arb2 u_arb (
    .valid (req),
    .last  (last_grant_q),
    .grant (grant)
  );

  // A disabled configuration drains both inputs without feeding the matcher.
  assign ifd_ready  = DRAIN | grant[0];
  assign exec_ready = DRAIN | grant[1];
  assign accept     = |grant;
  assign in_code    = grant[1] ? exec_code : ifd_code;

  always_comb begin
    state_d      = state_q;
    seq_hit_d    = 1'b0;
    hit_count_d  = hit_count_q;
    last_grant_d = last_grant_q;
    seq_done     = 1'b0;

    if (accept) begin
      last_grant_d = grant[1];
      if (in_code == CODE_W'(seq_code(state_q))) begin
        if (state_q == S5) begin
          state_d  = S0;
          seq_done = 1'b1;
        end else begin
          state_d = match_state_t'(state_q + 3'd1);
        end
      end else begin
        // A mismatching CLA_CLL can itself start a fresh attempt.
        state_d = (in_code == CODE_W'(CLA_CLL)) ? S1 : S0;
      end
    end

    if (seq_done) begin
      seq_hit_d = 1'b1;
      if (!(&hit_count_q)) hit_count_d = hit_count_q + CNT_W'(1);
    end

    // Clear discards any event completing in the same cycle.
    if (clear) begin
      state_d     = S0;
      seq_hit_d   = 1'b0;
      hit_count_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S0;
      seq_hit_q    <= 1'b0;
      hit_count_q  <= '0;
      last_grant_q <= 1'b1;
    end else begin
      state_q      <= state_d;
      seq_hit_q    <= seq_hit_d;
      hit_count_q  <= hit_count_d;
      last_grant_q <= last_grant_d;
    end
  end

  assign seq_step   = state_q;
  assign seq_hit    = seq_hit_q;
  assign hit_count  = hit_count_q;
  assign last_grant = last_grant_q;

endmodule

// File: tb/tb_seq_match_scheduler.sv
// Bench for seq_match_scheduler: four configurations (MODE 0 wide counter, MODE 0
// 2-bit counter, MODE 3, MODE 1) share stimulus and are checked against a reference model.
module tb_seq_match_scheduler;

  logic        clk = 1'b0;
  logic        reset, clear, ifd_valid, exec_valid;
  logic [3:0]  ifd_code, exec_code;

  logic [3:0]  o_ir, o_er, o_hit, o_last;
  logic [2:0]  o_step [4];
  logic [15:0] c0, c2, c3;
  logic [1:0]  c1;

  int ntot = 0;
  int nbad = 0;

  // Reference model state, one slot per instance.
  int modes [4]  = '{0, 0, 3, 1};
  int cmax  [4]  = '{65535, 3, 65535, 65535};
  int tb_seq [6] = '{1, 2, 2, 3, 4, 5};
  int m_step [4] = '{0, 0, 0, 0};
  int m_cnt  [4] = '{0, 0, 0, 0};
  bit m_hit  [4] = '{0, 0, 0, 0};
  bit m_last [4] = '{1, 1, 1, 1};
  bit e_ir   [4];
  bit e_er   [4];
  bit s_ir   [4];
  bit s_er   [4];

  always #5 clk = ~clk;

  seq_match_scheduler #(.MODE(0), .CNT_W(16)) d_main (
    .clk(clk), .reset(reset), .ifd_valid(ifd_valid), .ifd_code(ifd_code), .ifd_ready(o_ir[0]),
    .exec_valid(exec_valid), .exec_code(exec_code), .exec_ready(o_er[0]), .clear(clear),
    .seq_step(o_step[0]), .seq_hit(o_hit[0]), .hit_count(c0), .last_grant(o_last[0]));

  seq_match_scheduler #(.MODE(0), .CNT_W(2)) d_sat (
    .clk(clk), .reset(reset), .ifd_valid(ifd_valid), .ifd_code(ifd_code), .ifd_ready(o_ir[1]),
    .exec_valid(exec_valid), .exec_code(exec_code), .exec_ready(o_er[1]), .clear(clear),
    .seq_step(o_step[1]), .seq_hit(o_hit[1]), .hit_count(c1), .last_grant(o_last[1]));

  seq_match_scheduler #(.MODE(3), .CNT_W(16)) d_off (
    .clk(clk), .reset(reset), .ifd_valid(ifd_valid), .ifd_code(ifd_code), .ifd_ready(o_ir[2]),
    .exec_valid(exec_valid), .exec_code(exec_code), .exec_ready(o_er[2]), .clear(clear),
    .seq_step(o_step[2]), .seq_hit(o_hit[2]), .hit_count(c2), .last_grant(o_last[2]));

  seq_match_scheduler #(.MODE(1), .CNT_W(16)) d_ifd (
    .clk(clk), .reset(reset), .ifd_valid(ifd_valid), .ifd_code(ifd_code), .ifd_ready(o_ir[3]),
    .exec_valid(exec_valid), .exec_code(exec_code), .exec_ready(o_er[3]), .clear(clear),
    .seq_step(o_step[3]), .seq_hit(o_hit[3]), .hit_count(c3), .last_grant(o_last[3]));

  function automatic int get_cnt(input int k);
    case (k)
      0:       return int'(c0);
      1:       return int'(c1);
      2:       return int'(c2);
      default: return int'(c3);
    endcase
  endfunction

  // Drive one cycle, sample the combinational readies, advance the model, step past the edge.
  task automatic step_cycle(input bit iv, input int ic, input bit ev, input int ec,
                            input bit clr, input bit rst);
    ifd_valid = iv; ifd_code = 4'(ic); exec_valid = ev; exec_code = 4'(ec);
    clear = clr; reset = rst;
    #1;
    for (int k = 0; k < 4; k++) begin
      bit en_i, en_e, vi, ve, gi, ge;
      int code;
      s_ir[k] = o_ir[k];
      s_er[k] = o_er[k];
      en_i = (modes[k] == 0) || (modes[k] == 1);
      en_e = (modes[k] == 0) || (modes[k] == 2);
      vi = iv && en_i;
      ve = ev && en_e;
      if (vi && ve) begin gi = m_last[k]; ge = !m_last[k]; end
      else begin gi = vi; ge = ve; end
      e_ir[k] = (modes[k] == 3) ? 1'b1 : gi;
      e_er[k] = (modes[k] == 3) ? 1'b1 : ge;
      if (rst) begin
        m_step[k] = 0; m_cnt[k] = 0; m_hit[k] = 0; m_last[k] = 1;
      end else begin
        m_hit[k] = 0;
        if (gi || ge) m_last[k] = ge;
        code = ge ? ec : ic;
        if (clr) begin
          m_step[k] = 0; m_cnt[k] = 0;
        end else if (gi || ge) begin
          if (code == tb_seq[m_step[k]]) begin
            m_step[k]++;
            if (m_step[k] == 6) begin
              m_step[k] = 0;
              m_hit[k]  = 1;
              if (m_cnt[k] < cmax[k]) m_cnt[k]++;
            end
          end else begin
            m_step[k] = (code == 1) ? 1 : 0;
          end
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    step_cycle(0, 0, 0, 0, 0, 1);
    step_cycle(0, 0, 0, 0, 1, 1);
    for (int k = 0; k < 4; k++) begin
      ntot += 4;
      if (o_step[k] !== 3'd0) begin nbad++; $display("FAIL reset_step k=%0d got=%0d exp=0", k, o_step[k]); end
      if (o_hit[k] !== 1'b0) begin nbad++; $display("FAIL reset_hit k=%0d got=%b exp=0", k, o_hit[k]); end
      if (get_cnt(k) != 0) begin nbad++; $display("FAIL reset_cnt k=%0d got=%0d exp=0", k, get_cnt(k)); end
      if (o_last[k] !== 1'b1) begin nbad++; $display("FAIL reset_last k=%0d got=%b exp=1", k, o_last[k]); end
    end
  endtask

  task automatic test_basic_seq;
    int codes [6];
    int exp_s [6];
    codes = '{1, 2, 2, 3, 4, 5};
    exp_s = '{1, 2, 3, 4, 5, 0};
    step_cycle(0, 0, 0, 0, 0, 1);
    for (int i = 0; i < 6; i++) begin
      step_cycle(1, codes[i], 0, 0, 0, 0);
      ntot += 3;
      if (s_ir[0] !== 1'b1) begin nbad++; $display("FAIL basic_ready i=%0d got=%b exp=1", i, s_ir[0]); end
      if (o_step[0] !== 3'(exp_s[i])) begin nbad++; $display("FAIL basic_step i=%0d got=%0d exp=%0d", i, o_step[0], exp_s[i]); end
      if (o_hit[0] !== (i == 5)) begin nbad++; $display("FAIL basic_hit i=%0d got=%b exp=%b", i, o_hit[0], i == 5); end
    end
    step_cycle(0, 0, 0, 0, 0, 0);
    ntot += 2;
    if (o_hit[0] !== 1'b0) begin nbad++; $display("FAIL basic_hit_idle got=%b exp=0", o_hit[0]); end
    if (get_cnt(0) != 1) begin nbad++; $display("FAIL basic_cnt got=%0d exp=1", get_cnt(0)); end
    // Reset mid-sequence, even with an event presented, returns to S0.
    step_cycle(1, 1, 0, 0, 0, 0);
    step_cycle(1, 2, 0, 0, 0, 0);
    step_cycle(1, 2, 0, 0, 1, 1);
    ntot += 2;
    if (o_step[0] !== 3'd0) begin nbad++; $display("FAIL midreset_step got=%0d exp=0", o_step[0]); end
    if (get_cnt(0) != 0) begin nbad++; $display("FAIL midreset_cnt got=%0d exp=0", get_cnt(0)); end
  endtask

  task automatic test_tie_rr;
    step_cycle(0, 0, 0, 0, 0, 1);
    for (int i = 0; i < 4; i++) begin
      bit exp_i;
      exp_i = (i % 2 == 0);
      step_cycle(1, 0, 1, 0, 0, 0);
      ntot += 6;
      if (s_ir[0] !== exp_i) begin nbad++; $display("FAIL tie_ifd_ready i=%0d got=%b exp=%b", i, s_ir[0], exp_i); end
      if (s_er[0] !== !exp_i) begin nbad++; $display("FAIL tie_exec_ready i=%0d got=%b exp=%b", i, s_er[0], !exp_i); end
      if (s_ir[3] !== 1'b1) begin nbad++; $display("FAIL mode1_ifd_ready i=%0d got=%b exp=1", i, s_ir[3]); end
      if (s_er[3] !== 1'b0) begin nbad++; $display("FAIL mode1_exec_ready i=%0d got=%b exp=0", i, s_er[3]); end
      if ((s_ir[2] & s_er[2]) !== 1'b1) begin nbad++; $display("FAIL mode3_ready i=%0d got=%b%b exp=11", i, s_ir[2], s_er[2]); end
      if (o_last[0] !== !exp_i) begin nbad++; $display("FAIL tie_last i=%0d got=%b exp=%b", i, o_last[0], !exp_i); end
    end
  endtask

  task automatic test_restart;
    int codes [8];
    int hits;
    codes = '{1, 2, 1, 2, 2, 3, 4, 5};
    hits = 0;
    step_cycle(0, 0, 0, 0, 0, 1);
    for (int i = 0; i < 8; i++) begin
      step_cycle(1, codes[i], 0, 0, 0, 0);
      if (o_hit[0] === 1'b1) hits++;
      if (i == 2) begin
        ntot++;
        if (o_step[0] !== 3'd1) begin nbad++; $display("FAIL restart_step got=%0d exp=1", o_step[0]); end
      end
    end
    step_cycle(0, 0, 0, 0, 0, 0);
    if (o_hit[0] === 1'b1) hits++;
    ntot += 3;
    if (hits != 1) begin nbad++; $display("FAIL restart_hits got=%0d exp=1", hits); end
    if (get_cnt(0) != 1) begin nbad++; $display("FAIL restart_cnt got=%0d exp=1", get_cnt(0)); end
    if (o_step[0] !== 3'd0) begin nbad++; $display("FAIL restart_final_step got=%0d exp=0", o_step[0]); end
  endtask

  task automatic test_clear_final;
    int codes [6];
    codes = '{1, 2, 2, 3, 4, 5};
    step_cycle(0, 0, 0, 0, 0, 1);
    for (int i = 0; i < 6; i++) step_cycle(0, 0, 1, codes[i], 0, 0);
    for (int i = 0; i < 5; i++) step_cycle(0, 0, 1, codes[i], 0, 0);
    ntot += 2;
    if (o_step[0] !== 3'd5) begin nbad++; $display("FAIL clear_pre_step got=%0d exp=5", o_step[0]); end
    if (get_cnt(0) != 1) begin nbad++; $display("FAIL clear_pre_cnt got=%0d exp=1", get_cnt(0)); end
    step_cycle(0, 0, 1, 5, 1, 0);
    ntot += 4;
    if (s_er[0] !== 1'b1) begin nbad++; $display("FAIL clear_ready got=%b exp=1", s_er[0]); end
    if (o_hit[0] !== 1'b0) begin nbad++; $display("FAIL clear_hit got=%b exp=0", o_hit[0]); end
    if (get_cnt(0) != 0) begin nbad++; $display("FAIL clear_cnt got=%0d exp=0", get_cnt(0)); end
    if (o_step[0] !== 3'd0) begin nbad++; $display("FAIL clear_step got=%0d exp=0", o_step[0]); end
    step_cycle(0, 0, 0, 0, 0, 0);
    ntot += 2;
    if (o_hit[0] !== 1'b0) begin nbad++; $display("FAIL clear_hit_late got=%b exp=0", o_hit[0]); end
    if (o_last[0] !== 1'b1) begin nbad++; $display("FAIL clear_last got=%b exp=1", o_last[0]); end
  endtask

  task automatic test_saturation;
    int codes [6];
    int pulses;
    codes = '{1, 2, 2, 3, 4, 5};
    pulses = 0;
    step_cycle(0, 0, 0, 0, 0, 1);
    for (int r = 0; r < 4; r++) begin
      for (int i = 0; i < 6; i++) begin
        step_cycle(1, codes[i], 0, 0, 0, 0);
        if (o_hit[1] === 1'b1) pulses++;
      end
      if (r >= 2) begin
        ntot++;
        if (get_cnt(1) != 3) begin nbad++; $display("FAIL sat_cnt r=%0d got=%0d exp=3", r, get_cnt(1)); end
      end
    end
    ntot += 2;
    if (pulses != 4) begin nbad++; $display("FAIL sat_pulses got=%0d exp=4", pulses); end
    if (get_cnt(0) != 4) begin nbad++; $display("FAIL wide_cnt got=%0d exp=4", get_cnt(0)); end
  endtask

  task automatic test_random;
    step_cycle(0, 0, 0, 0, 0, 1);
    for (int n = 0; n < 600; n++) begin
      bit iv, ev, clr, rst;
      int ic, ec;
      iv  = ($urandom % 4) != 0;
      ev  = ($urandom % 2) != 0;
      clr = ($urandom % 40) == 0;
      rst = ($urandom % 150) == 0;
      ic  = (($urandom % 10) < 7) ? tb_seq[m_step[0]] : int'($urandom % 10);
      ec  = (($urandom % 10) < 7) ? tb_seq[m_step[0]] : int'($urandom % 10);
      step_cycle(iv, ic, ev, ec, clr, rst);
      for (int k = 0; k < 4; k++) begin
        ntot += 7;
        if (s_ir[k] !== e_ir[k]) begin nbad++; $display("FAIL rnd_ifd_ready n=%0d k=%0d got=%b exp=%b", n, k, s_ir[k], e_ir[k]); end
        if (s_er[k] !== e_er[k]) begin nbad++; $display("FAIL rnd_exec_ready n=%0d k=%0d got=%b exp=%b", n, k, s_er[k], e_er[k]); end
        if (k != 2 && (s_ir[k] & s_er[k])) begin nbad++; $display("FAIL rnd_both_ready n=%0d k=%0d got=11 exp=one-hot", n, k); end
        if (o_step[k] !== 3'(m_step[k])) begin nbad++; $display("FAIL rnd_step n=%0d k=%0d got=%0d exp=%0d", n, k, o_step[k], m_step[k]); end
        if (o_hit[k] !== m_hit[k]) begin nbad++; $display("FAIL rnd_hit n=%0d k=%0d got=%b exp=%b", n, k, o_hit[k], m_hit[k]); end
        if (get_cnt(k) != m_cnt[k]) begin nbad++; $display("FAIL rnd_cnt n=%0d k=%0d got=%0d exp=%0d", n, k, get_cnt(k), m_cnt[k]); end
        if (o_last[k] !== m_last[k]) begin nbad++; $display("FAIL rnd_last n=%0d k=%0d got=%b exp=%b", n, k, o_last[k], m_last[k]); end
      end
    end
  endtask

  initial begin
    reset = 1'b1; clear = 1'b0; ifd_valid = 1'b0; exec_valid = 1'b0;
    ifd_code = 4'd0; exec_code = 4'd0;
    test_reset();
    test_basic_seq();
    test_tie_rr();
    test_restart();
    test_clear_final();
    test_saturation();
    test_random();
    $display("test done: total=%0d bad=%0d", ntot, nbad);
    $finish;
  end

endmodule

// File: doc/seq_match_scheduler.md
SEQ_MATCH_SCHEDULER -- requirements
Module: seq_match_scheduler

Interface
REQ-001 SHALL have parameter MODE, default 0, meaning requester enable: 0 = IFD+EXEC, 1 = IFD only, 2 = EXEC only, 3 = disabled.
REQ-002 SHALL have parameter CNT_W, default 16, meaning hit-counter width.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port ifd_valid  input  1  IFD-stage observation event present.
REQ-006 SHALL have port ifd_code  input  4  IFD event code (obs_code_t).
REQ-007 SHALL have port ifd_ready  output  1  IFD event accepted this cycle.
REQ-008 SHALL have port exec_valid  input  1  EXEC-stage observation event present.
REQ-009 SHALL have port exec_code  input  4  EXEC event code (obs_code_t).
REQ-010 SHALL have port exec_ready  output  1  EXEC event accepted this cycle.
REQ-011 SHALL have port clear  input  1  synchronous clear of matcher and counter.
REQ-012 SHALL have port seq_step  output  3  matched-prefix length, 0..5.
REQ-013 SHALL have port seq_hit  output  1  one-cycle pulse on full-sequence completion.
REQ-014 SHALL have port hit_count  output  CNT_W  saturating count of completed sequences.
REQ-015 SHALL have port last_grant  output  1  requester granted most recently (0 = IFD, 1 = EXEC).

Function
REQ-016 Arbitration SHALL be single-grant, combinational: ready asserts only to the granted valid requester, never to both in one cycle.
REQ-017 When both are enabled and valid, the grant SHALL go to the requester not equal to last_grant (round-robin); last_grant updates on each accepted event.
REQ-018 A requester disabled by MODE SHALL have ready = 0, and its valid SHALL be ignored.
REQ-019 In MODE 3, both ready outputs SHALL be held 1 (events drained); seq_step, seq_hit and hit_count SHALL stay 0.
REQ-020 The target sequence SHALL be SEQ[0..5] = CLA_CLL, TAD, TAD, DCA, HLT, JMP.
REQ-021 The matcher is an FSM with states S0..S5 (state index = seq_step); on an accepted event only: code == SEQ[step] -> step+1.
REQ-022 On a mismatch, the next state SHALL be S1 if code == CLA_CLL, else S0.
REQ-023 In S5, an accepted JMP SHALL return the matcher to S0, pulse seq_hit on the following cycle, and increment hit_count.
REQ-024 hit_count SHALL saturate at all-ones; a hit at saturation still pulses seq_hit.
REQ-025 Cycles without an accepted event SHALL leave the FSM, counter and last_grant unchanged; NONE-coded events are accepted and treated as mismatches.
REQ-026 Latency: seq_step and hit_count reflect an accepted event one clock after the handshake.
REQ-027 clear SHALL force S0, seq_hit = 0, hit_count = 0 next edge; clear wins over a simultaneous completing event, and that event is discarded.
REQ-028 clear SHALL not alter last_grant and SHALL not block ready.

Reset
REQ-029 On reset: S0, seq_step = 0, seq_hit = 0, hit_count = 0, last_grant = 1 (so IFD wins the first tie).
REQ-030 Reset SHALL take priority over clear and any handshake, including mid-sequence; ready outputs remain combinational from valid and MODE during reset.

Structure
REQ-031 Package obs_pkg SHALL hold obs_code_t (NONE = 0, CLA_CLL, TAD, DCA, HLT, JMP, ISZ, JMS, IOT, OTHER), the SEQ_LEN = 6 constant, the SEQ table, and the MODE encodings.
REQ-032 The round-robin arbiter SHALL be a sub-module rr_arb2 (valid[1:0], last -> grant[1:0]); the matcher FSM and counter stay in the top module.

Verification
REQ-033 Inputs CLA_CLL, TAD, TAD, DCA, HLT, JMP from IFD only, one per cycle, MODE 0 -> seq_step 1..5 then 0; seq_hit pulses once; hit_count = 1.
REQ-034 Both valid for 4 cycles after reset -> grants IFD, EXEC, IFD, EXEC; never both readies high at once.
REQ-035 Stream CLA_CLL, TAD, CLA_CLL, TAD, TAD, DCA, HLT, JMP -> seq_step = 1 after the 3rd event; exactly one hit.
REQ-036 clear asserted in the same cycle as the final JMP is accepted -> no seq_hit; hit_count = 0; seq_step = 0.
REQ-037 CNT_W = 2, four full sequences -> hit_count = 3 after the 3rd and the 4th; seq_hit pulses 4 times.
REQ-038 MODE 3 with random valid events -> both readies = 1 every cycle; outputs stay 0; MODE 1 -> exec_ready is always 0.
